// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path constants: reset vector, text-segment word base,
// fetch FSM state encoding and the NOP encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] TEXT_BASE_WORD   = 32'h0010_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-to-decode instruction handshake; the sequencer drives the master side.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;

  modport master (
    output inst_valid,
    output inst_data,
    output inst_pc,
    output pc_plus4,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    input  pc_plus4,
    output inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Shallow {pc, instruction} FIFO. The head always lives in slot 0, so the
// decode-facing outputs come straight from flops; flush wins over push.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               flush,
  input  logic [DATA_WIDTH-1:0]              push_pc,
  input  logic [DATA_WIDTH-1:0]              push_data,
  output logic [DATA_WIDTH-1:0]              head_pc,
  output logic [DATA_WIDTH-1:0]              head_data,
  output logic [DATA_WIDTH-1:0]              head_pc_plus4,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  logic [DATA_WIDTH-1:0] pc_mem_r   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] pcp4_mem_r [QUEUE_DEPTH];
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_next_s;
  logic [CW-1:0]         wr_slot_s;
  logic [AW-1:0]         wr_idx_s;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  assign full          = (count_r == DEPTH_C);
  assign empty         = (count_r == {CW{1'b0}});
  assign count         = count_r;
  assign head_pc       = pc_mem_r[0];
  assign head_data     = data_mem_r[0];
  assign head_pc_plus4 = pcp4_mem_r[0];

  // Handshake qualification, next occupancy and the slot a push lands in after any shift.
  always_comb begin
    pop_ok_s     = pop & ~empty;
    push_ok_s    = push & (~full | pop_ok_s);
    count_next_s = count_r;
    if (pop_ok_s) begin
      wr_slot_s = count_r - ONE_C;
    end else begin
      wr_slot_s = count_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
    wr_idx_s = wr_slot_s[AW-1:0];
  end

  // Storage update: shift on pop, then write the new entry behind the survivors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_r[i]   <= {DATA_WIDTH{1'b0}};
        data_mem_r[i] <= DATA_WIDTH'(NOP_INSTR);
        pcp4_mem_r[i] <= DATA_WIDTH'(3'd4);
      end
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else begin
      if (pop_ok_s) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
          pc_mem_r[i]   <= pc_mem_r[i+1];
          data_mem_r[i] <= data_mem_r[i+1];
          pcp4_mem_r[i] <= pcp4_mem_r[i+1];
        end
      end
      if (push_ok_s) begin
        pc_mem_r[wr_idx_s]   <= push_pc;
        data_mem_r[wr_idx_s] <= push_data;
        pcp4_mem_r[wr_idx_s] <= push_pc + DATA_WIDTH'(3'd4);
      end
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, drives a combinational program ROM and queues fetched words for decode.
// Optional macro FETCH_BOUNDS_CHECK_EN adds the fetch_fault output and range check.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_instruction,
  fetch_sequencer_if.master     inst,
  output logic [1:0]            fetch_state
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic                  fetch_fault
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0]         LAST_SLOT_C   = CW'(QUEUE_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] BASE_WORD_C   = RESET_PC >> 2;
  localparam logic [DATA_WIDTH-1:0] DEPTH_WORDS_C = DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] FOUR_C        = DATA_WIDTH'(3'd4);
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN_C = 1'b1;
`else
  localparam logic BOUNDS_EN_C = 1'b0;
`endif

  fetch_state_e          state_r;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] target_s;
  logic                  fault_r;
  logic                  pop_s;
  logic                  push_s;
  logic                  oob_s;
  logic                  target_oob_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CW-1:0]         count_s;
  logic [DATA_WIDTH-1:0] head_pc_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [DATA_WIDTH-1:0] head_pcp4_s;

  // Word index relative to the text base; addresses below the base wrap to huge indices.
  function automatic logic pc_out_of_range(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] word_idx;
    word_idx = (pc >> 2) - BASE_WORD_C;
    return BOUNDS_EN_C & (word_idx >= DEPTH_WORDS_C);
  endfunction

  // Fetch decision: redirect suppresses the push; otherwise fetch while a slot is or becomes free.
  always_comb begin
    target_s     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    pop_s        = inst.inst_valid & inst.inst_ready;
    oob_s        = pc_out_of_range(pc_r);
    target_oob_s = pc_out_of_range(target_s);
    push_s       = 1'b0;
    if (!redirect_valid && enable && (state_r == ST_FETCH) && !oob_s && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Fetch FSM with PC and fault registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r    <= RESET_PC;
      state_r <= ST_IDLE;
      fault_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r    <= target_s;
      state_r <= enable ? ST_FETCH : ST_IDLE;
      fault_r <= target_oob_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && !fault_r) state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!enable) begin
            state_r <= ST_IDLE;
          end else if (oob_s) begin
            fault_r <= 1'b1;
            state_r <= ST_IDLE;
          end else if (push_s) begin
            pc_r <= pc_r + FOUR_C;
            if (!pop_s && (count_s == LAST_SLOT_C)) state_r <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop_s) state_r <= ST_FETCH;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DATA_WIDTH  (DATA_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk           (clk),
    .reset         (reset),
    .push          (push_s),
    .pop           (pop_s),
    .flush         (redirect_valid),
    .push_pc       (pc_r),
    .push_data     (rom_instruction),
    .head_pc       (head_pc_s),
    .head_data     (head_data_s),
    .head_pc_plus4 (head_pcp4_s),
    .count         (count_s),
    .full          (full_s),
    .empty         (empty_s)
  );

  assign rom_address     = pc_r;
  assign fetch_state     = state_r;
  assign inst.inst_valid = ~empty_s;
  assign inst.inst_data  = head_data_s;
  assign inst.inst_pc    = head_pc_s;
  assign inst.pc_plus4   = head_pcp4_s;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fetch_fault     = fault_r;
`endif

endmodule
